xbus_arb: RTL and testbench
===========================

XBUS_ARB -- requirements
Module: xbus_arb

Interface
REQ-001 Parameter TIMEOUT, default 8'd32: number of cycles xb_req may stay high without xb_ack before the cycle is aborted as non-existent memory (NXM).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 m0_addr / m1_addr  input  22  master 0 (CPU) / master 1 (DMA) xbus word address.
REQ-005 m0_datain / m1_datain  input  32  master write data.
REQ-006 m0_req / m1_req  input  1  master request; held high until ack, then dropped.
REQ-007 m0_write / m1_write  input  1  1 = write, 0 = read.
REQ-008 m0_dataout / m1_dataout  output  32  read data returned to master.
REQ-009 m0_ack / m1_ack  output  1  cycle complete to that master.
REQ-010 m0_nxm / m1_nxm  output  1  cycle aborted by timeout; valid while the matching ack is high.
REQ-011 xb_addr  output  22  address to xbus slaves.
REQ-012 xb_dataout  output  32  write data to slaves.
REQ-013 xb_req / xb_write  output  1 / 1  slave request and direction.
REQ-014 xb_datain  input  32  OR of slave read data.
REQ-015 xb_ack / xb_decode  input  1 / 1  OR of slave ack / address-decode.
REQ-016 busy / owner  output  1 / 1  arbiter not IDLE / index of the granted master.

Function
REQ-017 Four states SHALL be used: IDLE, GRANT, XFER, DONE.
REQ-018 IDLE: if any mN_req is high, the block SHALL latch that master's addr, datain and write, set owner, and go to GRANT; otherwise it SHALL stay in IDLE.
REQ-019 Both requests high in IDLE: the grant SHALL go to the master other than last_owner (round-robin); last_owner SHALL update at each grant.
REQ-020 GRANT SHALL last exactly one cycle, clear the timeout counter, and go to XFER.
REQ-021 XFER: xb_req SHALL be high, with xb_addr, xb_dataout and xb_write driven from the latched values; the counter SHALL increment each cycle.
REQ-022 XFER with xb_ack=1: the block SHALL capture xb_datain (reads only; writes capture 0), set nxm=0, drop xb_req and go to DONE.
REQ-023 XFER with xb_ack=0 and counter==TIMEOUT-1: the block SHALL capture data=0, set nxm=1, drop xb_req and go to DONE.
REQ-024 xb_ack and timeout in the same cycle: xb_ack SHALL win (nxm=0).
REQ-025 xb_decode SHALL NOT change sequencing; its only effect is that busy-with-decode may be observed by the bench.
REQ-026 DONE: only the owner's mN_ack SHALL be high, with mN_dataout = captured data and mN_nxm = captured nxm; the other master's outputs SHALL be 0.
REQ-027 DONE SHALL exit to IDLE in the cycle after the owner's mN_req is sampled low (four-phase handshake); the non-owner's request SHALL wait.
REQ-028 Outside XFER, xb_req SHALL be 0 and xb_addr, xb_dataout and xb_write SHALL be 0.
REQ-029 Outside DONE, all mN_ack, mN_nxm and mN_dataout SHALL be 0.
REQ-030 Latency, request to xb_req: 2 cycles (IDLE->GRANT->XFER); xb_ack to mN_ack: 1 cycle.
REQ-031 Master inputs changing after grant SHALL NOT affect the cycle in progress.
REQ-032 The counter SHALL be 8 bits and SHALL saturate, never wrap, within XFER.

Reset
REQ-033 reset_n low SHALL immediately force IDLE, with every output 0, counter 0 and last_owner=1 (so m0 wins the first tie).
REQ-034 Reset asserted mid-XFER SHALL drop xb_req asynchronously, with no ack issued to either master.

Verification
REQ-035 m0 reads 22'o17772052, slave acks 2 cycles after xb_req with data 32'h12345678 -> xb_req high 2 cycles after m0_req; m0_ack=1, m0_dataout=32'h12345678, m0_nxm=0; IDLE after m0_req drops.
REQ-036 m0_req and m1_req both rise in the first cycle after reset -> m0 served first, then m1; on the next simultaneous request m0 is served first again.
REQ-037 m1 writes 22'o17772045 with data 4'hA -> xb_write=1, xb_dataout=32'hA during XFER; m1_ack=1, m1_dataout=0.
REQ-038 m0 reads an undecoded address, slave never acks -> xb_req high exactly 32 cycles, then m0_ack=1, m0_nxm=1, m0_dataout=0.
REQ-039 xb_ack arrives on the 32nd XFER cycle -> m0_nxm=0 and data captured.
REQ-040 reset_n pulsed low mid-XFER -> xb_req, busy and acks are 0 immediately; after release, a pending m1_req is granted normally.

Source files
------------

// File: rtl/xbus_arb.sv
// Two-master xbus arbiter: round-robin grant, single outstanding slave cycle,
// timeout abort reported to the master as non-existent memory (NXM).
module xbus_arb #(
    parameter logic [7:0] TIMEOUT = 8'd32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [21:0] m0_addr,
    input  logic [21:0] m1_addr,
    input  logic [31:0] m0_datain,
    input  logic [31:0] m1_datain,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_write,
    input  logic        m1_write,
    output logic [31:0] m0_dataout,
    output logic [31:0] m1_dataout,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic        m0_nxm,
    output logic        m1_nxm,
    output logic [21:0] xb_addr,
    output logic [31:0] xb_dataout,
    output logic        xb_req,
    output logic        xb_write,
    input  logic [31:0] xb_datain,
    input  logic        xb_ack,
    input  logic        xb_decode,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {IDLE, GRANT, XFER, DONE} state_t;

    localparam logic [7:0] TO_LAST = TIMEOUT - 8'd1;

    state_t      state, state_nx;
    logic        grant;
    logic        grant_m;
    logic        owner_r;
    logic        last_owner;
    logic [21:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_write;
    logic [31:0] cap_data;
    logic        cap_nxm;
    logic [7:0]  cnt;
    logic        owner_req;
    logic        unused_decode;

    // Address decode is informational only; it never steers sequencing.
    assign unused_decode = xb_decode;

    assign owner_req = owner_r ? m1_req : m0_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        grant_m  = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant    = 1'b1;
                    state_nx = GRANT;
                    if (m0_req && m1_req) grant_m = ~last_owner;
                    else                  grant_m = m1_req;
                end
            end
            GRANT: state_nx = XFER;
            XFER: begin
                if (xb_ack || (cnt == TO_LAST)) state_nx = DONE;
            end
            DONE: begin
                if (!owner_req) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_r    <= 1'b0;
            last_owner <= 1'b1;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_write  <= 1'b0;
            cap_data   <= '0;
            cap_nxm    <= 1'b0;
            cnt        <= '0;
        end else begin
            if (grant) begin
                owner_r    <= grant_m;
                last_owner <= grant_m;
                lat_addr   <= grant_m ? m1_addr   : m0_addr;
                lat_wdata  <= grant_m ? m1_datain : m0_datain;
                lat_write  <= grant_m ? m1_write  : m0_write;
            end
            if (state == GRANT) begin
                cnt <= '0;
            end else if (state == XFER && cnt != '1) begin
                cnt <= cnt + 8'd1;
            end
            // A slave ack on the final count still completes normally.
            if (state == XFER) begin
                if (xb_ack) begin
                    cap_data <= lat_write ? '0 : xb_datain;
                    cap_nxm  <= 1'b0;
                end else if (cnt == TO_LAST) begin
                    cap_data <= '0;
                    cap_nxm  <= 1'b1;
                end
            end
        end
    end

    assign busy       = (state != IDLE);
    assign owner      = owner_r;

    assign xb_req     = (state == XFER);
    assign xb_addr    = xb_req ? lat_addr  : '0;
    assign xb_dataout = xb_req ? lat_wdata : '0;
    assign xb_write   = xb_req & lat_write;

    assign m0_ack     = (state == DONE) & ~owner_r;
    assign m1_ack     = (state == DONE) &  owner_r;
    assign m0_dataout = m0_ack ? cap_data : '0;
    assign m1_dataout = m1_ack ? cap_data : '0;
    assign m0_nxm     = m0_ack & cap_nxm;
    assign m1_nxm     = m1_ack & cap_nxm;

endmodule

// File: tb/tb_xbus_arb.sv
// Scoreboard bench for xbus_arb: stimulus predicts grant order and slave outcome,
// a negedge monitor checks the xbus cycle and the master response against it.
module tb_xbus_arb;

    localparam int unsigned TO    = 32;
    localparam int unsigned NEVER = 1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [21:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_datain = '0, m1_datain = '0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic        m0_write = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_dataout, m1_dataout;
    logic        m0_ack, m1_ack, m0_nxm, m1_nxm;
    logic [21:0] xb_addr;
    logic [31:0] xb_dataout;
    logic        xb_req, xb_write;
    logic [31:0] xb_datain = '0;
    logic        xb_ack = 1'b0;
    logic        xb_decode = 1'b0;
    logic        busy, owner;

    xbus_arb #(.TIMEOUT(8'd32)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_datain(m0_datain), .m1_datain(m1_datain),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_write(m0_write), .m1_write(m1_write),
        .m0_dataout(m0_dataout), .m1_dataout(m1_dataout),
        .m0_ack(m0_ack), .m1_ack(m1_ack),
        .m0_nxm(m0_nxm), .m1_nxm(m1_nxm),
        .xb_addr(xb_addr), .xb_dataout(xb_dataout),
        .xb_req(xb_req), .xb_write(xb_write),
        .xb_datain(xb_datain), .xb_ack(xb_ack), .xb_decode(xb_decode),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          m;
        logic [21:0] addr;
        logic [31:0] wdata;
        bit          write;
        int unsigned delay;
        logic [31:0] rdata;
        int          t0;
    } txn_t;

    txn_t exp_q[$];
    txn_t slv_q[$];
    bit   model_last = 1'b1;

    function automatic txn_t mk(input bit m, input logic [21:0] a, input logic [31:0] d,
                                input bit w, input int unsigned dly, input logic [31:0] rd);
        txn_t t;
        t.m = m; t.addr = a; t.wdata = d; t.write = w; t.delay = dly; t.rdata = rd; t.t0 = -1;
        return t;
    endfunction

    function automatic bit exp_nxm(input txn_t t);
        return t.delay >= TO;
    endfunction

    function automatic logic [31:0] exp_data(input txn_t t);
        return (t.write || t.delay >= TO) ? 32'h0 : t.rdata;
    endfunction

    function automatic int unsigned exp_len(input txn_t t);
        return (t.delay >= TO) ? TO : t.delay + 1;
    endfunction

    // Slave: acks on XFER cycle 'delay' (0-based), never if delay >= TIMEOUT.
    txn_t        s_cur;
    bit          s_active = 1'b0;
    int unsigned s_k = 0;
    always @(negedge clk) begin
        xb_decode = 1'($urandom);
        if (!reset_n) begin
            s_active = 1'b0;
            xb_ack   = 1'b0;
        end else if (xb_req) begin
            if (!s_active) begin
                if (slv_q.size() > 0) s_cur = slv_q.pop_front();
                else                  s_cur = mk(1'b0, '0, '0, 1'b0, NEVER, '0);
                s_active = 1'b1;
                s_k = 0;
            end else begin
                s_k++;
            end
            xb_ack    = (s_k == s_cur.delay);
            xb_datain = xb_ack ? s_cur.rdata : $urandom;
        end else begin
            s_active  = 1'b0;
            xb_ack    = 1'b0;
            xb_datain = $urandom;
        end
    end

    // Monitor
    txn_t        cur;
    bit          cur_v = 1'b0;
    bit          prev_xr = 1'b0;
    bit          prev_ack = 1'b0;
    int unsigned xr_len = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            cur_v = 1'b0; prev_xr = 1'b0; prev_ack = 1'b0; xr_len = 0;
        end else begin
            if (xb_req && !prev_xr) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_xb_req", 32'(xb_req), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    cur_v = 1'b1;
                    xr_len = 0;
                    chk("grant_owner", 32'(owner), 32'(cur.m));
                    chk("busy_in_xfer", 32'(busy), 32'd1);
                    if (cur.t0 >= 0) chk("req_to_xbreq_latency", 32'(cyc - cur.t0), 32'd2);
                end
            end
            if (xb_req) begin
                xr_len++;
                if (cur_v) begin
                    chk("xb_addr", 32'(xb_addr), 32'(cur.addr));
                    chk("xb_dataout", xb_dataout, cur.wdata);
                    chk("xb_write", 32'(xb_write), 32'(cur.write));
                end
            end else begin
                chk("idle_xb_addr", 32'(xb_addr), 32'd0);
                chk("idle_xb_dataout", xb_dataout, 32'd0);
                chk("idle_xb_write", 32'(xb_write), 32'd0);
            end
            if (!xb_req && prev_xr && cur_v) begin
                chk("xb_req_length", 32'(xr_len), 32'(exp_len(cur)));
                chk("ack_latency", 32'(cur.m ? m1_ack : m0_ack), 32'd1);
            end
            if (m0_ack || m1_ack) begin
                if (cur_v) begin
                    chk("ack_master", {30'd0, m1_ack, m0_ack}, cur.m ? 32'd2 : 32'd1);
                    chk("dataout", cur.m ? m1_dataout : m0_dataout, exp_data(cur));
                    chk("nxm", 32'(cur.m ? m1_nxm : m0_nxm), 32'(exp_nxm(cur)));
                    chk("other_dataout", cur.m ? m0_dataout : m1_dataout, 32'd0);
                    chk("other_nxm", 32'(cur.m ? m0_nxm : m1_nxm), 32'd0);
                end else begin
                    chk("unexpected_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
                end
            end else begin
                chk("noack_dataout", m0_dataout | m1_dataout, 32'd0);
                chk("noack_nxm", 32'(m0_nxm | m1_nxm), 32'd0);
            end
            if (!(m0_ack || m1_ack) && prev_ack) cur_v = 1'b0;
            prev_ack = m0_ack | m1_ack;
            prev_xr  = xb_req;
        end
    end

    task automatic drive_wait(input bit m);
        int n = 0;
        while (!(busy && owner == m) && n < 400) begin @(negedge clk); n++; end
        chk(m ? "m1_granted" : "m0_granted", 32'(busy && owner == m), 32'd1);
        // Grant has latched the request; later input changes must be ignored.
        if (m) begin m1_addr = 22'($urandom); m1_datain = $urandom; m1_write = 1'($urandom); end
        else   begin m0_addr = 22'($urandom); m0_datain = $urandom; m0_write = 1'($urandom); end
        n = 0;
        while (!(m ? m1_ack : m0_ack) && n < 400) begin @(negedge clk); n++; end
        chk(m ? "m1_ack_seen" : "m0_ack_seen", 32'(m ? m1_ack : m0_ack), 32'd1);
        if (m) m1_req = 1'b0;
        else   m0_req = 1'b0;
    endtask

    task automatic run_round(input txn_t t0, input txn_t t1, input bit use0, input bit use1);
        txn_t first, second;
        @(negedge clk);
        if (use0 && use1) begin
            if (model_last) begin first = t0; second = t1; end
            else            begin first = t1; second = t0; end
        end else begin
            first = use0 ? t0 : t1;
        end
        first.t0 = cyc;
        exp_q.push_back(first);
        slv_q.push_back(first);
        model_last = first.m;
        if (use0 && use1) begin
            second.t0 = -1;
            exp_q.push_back(second);
            slv_q.push_back(second);
            model_last = second.m;
        end
        if (use0) begin m0_addr = t0.addr; m0_datain = t0.wdata; m0_write = t0.write; m0_req = 1'b1; end
        if (use1) begin m1_addr = t1.addr; m1_datain = t1.wdata; m1_write = t1.write; m1_req = 1'b1; end
        fork
            if (use0) drive_wait(1'b0);
            if (use1) drive_wait(1'b1);
        join
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    function automatic int unsigned rand_delay();
        case ($urandom_range(0, 9))
            0:       return TO - 1;
            1:       return TO;
            2:       return NEVER;
            3:       return 0;
            default: return $urandom_range(0, 12);
        endcase
    endfunction

    function automatic txn_t rand_txn(input bit m);
        return mk(m, 22'($urandom), $urandom, 1'($urandom), rand_delay(), $urandom);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t ta, tb;
        int   n;
        repeat (2) @(negedge clk);
        chk("rst_xb_req", 32'(xb_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        chk("rst_xb_addr", 32'(xb_addr), 32'd0);
        chk("rst_dataout", m0_dataout | m1_dataout, 32'd0);
        reset_n = 1'b1;

        // Simultaneous requests right after reset, then again: m0 first both times.
        run_round(mk(1'b0, 22'o17772052, 32'h0, 1'b0, 2, 32'h12345678),
                  mk(1'b1, 22'o17772045, 32'hA, 1'b1, 1, 32'hDEADBEEF), 1'b1, 1'b1);
        run_round(mk(1'b0, 22'o17772052, 32'h0, 1'b0, 4, 32'hCAFEF00D),
                  mk(1'b1, 22'o17772046, 32'h5, 1'b0, 0, 32'h0BADC0DE), 1'b1, 1'b1);
        // Solo read, solo write, no-ack timeout, ack on the last count, ack one too late.
        run_round(mk(1'b0, 22'o17772052, 32'h0, 1'b0, 2, 32'h12345678), ta, 1'b1, 1'b0);
        run_round(ta, mk(1'b1, 22'o17772045, 32'hA, 1'b1, 2, 32'h77777777), 1'b0, 1'b1);
        run_round(mk(1'b0, 22'o17000000, 32'h0, 1'b0, NEVER, 32'h11111111), ta, 1'b1, 1'b0);
        run_round(mk(1'b0, 22'o17772052, 32'h0, 1'b0, TO - 1, 32'hA5A5A5A5), ta, 1'b1, 1'b0);
        run_round(mk(1'b0, 22'o17772052, 32'h0, 1'b0, TO, 32'h5A5A5A5A), ta, 1'b1, 1'b0);

        for (int i = 0; i < 60; i++) begin
            int unsigned mask;
            mask = $urandom_range(1, 3);
            ta = rand_txn(1'b0);
            tb = rand_txn(1'b1);
            run_round(ta, tb, mask[0], mask[1]);
        end

        // Reset in the middle of a transfer, with m1 still requesting.
        @(negedge clk);
        ta = mk(1'b1, 22'o17654321, 32'h13579BDF, 1'b0, NEVER, 32'h0);
        ta.t0 = cyc;
        exp_q.push_back(ta);
        slv_q.push_back(ta);
        m1_addr = ta.addr; m1_datain = ta.wdata; m1_write = ta.write; m1_req = 1'b1;
        repeat (6) @(negedge clk);
        chk("pre_reset_xb_req", 32'(xb_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_xb_req", 32'(xb_req), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        model_last = 1'b1;
        ta.delay = 3;
        ta.rdata = 32'h2468ACE0;
        ta.t0 = -1;
        exp_q.push_back(ta);
        slv_q.push_back(ta);
        n = 0;
        while (!m1_ack && n < 100) begin @(negedge clk); n++; end
        chk("post_reset_m1_ack", 32'(m1_ack), 32'd1);
        m1_req = 1'b0;

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("final_idle", 32'(busy), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
